// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (instruction/data) arbiter onto one single-port synchronous memory.
// Define ARB_RR_EN for round-robin arbitration; default is fixed priority (data over instruction).
module mem_arbiter #(
  parameter int WORD = 32,
  parameter int ADDR = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_req,
  input  logic [ADDR-1:0] i_addr,
  output logic            i_gnt,
  output logic            i_rvalid,
  output logic [WORD-1:0] i_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [ADDR-1:0] d_addr,
  input  logic [WORD-1:0] d_wdata,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [WORD-1:0] d_rdata,
  output logic [ADDR-1:0] mem_A,
  output logic            mem_W,
  output logic [WORD-1:0] mem_D,
  input  logic [WORD-1:0] mem_Q
);
  typedef enum logic [1:0] {NONE, RESP_I, RESP_D} owner_t;
  owner_t r_owner, w_owner_nxt;
  logic   w_d_first;
`ifdef ARB_RR_EN
  logic r_last;
  // r_last=1 means the data port won most recently
  always_ff @(posedge clk)
    if (!rst_n) r_last <= 1'b0;
    else if (i_gnt || d_gnt) r_last <= d_gnt;
  assign w_d_first = ~r_last;
`else
  assign w_d_first = 1'b1;
`endif
  always_comb begin
    d_gnt = rst_n & d_req & (~i_req | w_d_first);
    i_gnt = rst_n & i_req & ~d_gnt;
    mem_A = d_gnt ? d_addr : i_addr;
    mem_W = d_gnt & d_we;
    mem_D = d_wdata;
  end
  always_ff @(posedge clk)
    if (!rst_n) r_owner <= NONE;
    else r_owner <= w_owner_nxt;
  always_comb
    w_owner_nxt = i_gnt ? RESP_I : (d_gnt && !d_we) ? RESP_D : NONE;
  // rst_n gating drops a response whose read was granted just before reset
  always_comb begin
    i_rvalid = rst_n && (r_owner == RESP_I);
    d_rvalid = rst_n && (r_owner == RESP_D);
    i_rdata  = mem_Q;
    d_rdata  = mem_Q;
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table plus randomized traffic against a scoreboard model.
module tb_mem_arbiter;
`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  localparam logic [31:0] W = 32'hDEADBEEF;
  localparam logic [31:0] C = 32'hC0DE0004;
  logic        clk, rst_n, i_req, i_gnt, i_rvalid, d_req, d_we, d_gnt, d_rvalid, mem_W;
  logic [15:0] i_addr, d_addr, mem_A;
  logic [31:0] i_rdata, d_rdata, d_wdata, mem_D, mem_Q;
  logic [31:0] ram [0:65535];
  logic [31:0] mm [int];
  int n_tests = 0, n_fail = 0;

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_A(mem_A), .mem_W(mem_W), .mem_D(mem_D), .mem_Q(mem_Q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_W) ram[mem_A] <= mem_D;
    mem_Q <= ram[mem_A];
  end

  function automatic logic [31:0] init_val(int a);
    return 32'hC0DE0000 | 32'(a);
  endfunction

  function automatic logic [31:0] mem_get(int a);
    return mm.exists(a) ? mm[a] : init_val(a);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    bit rst; bit ir; logic [15:0] ia;
    bit dr; bit dw; logic [15:0] da; logic [31:0] dd;
    bit eig; bit edg; bit ew; logic [15:0] ea;
    bit eirv; bit edrv; logic [31:0] erd;
  } vec_t;

  function automatic vec_t v(bit rst, bit ir, logic [15:0] ia, bit dr, bit dw, logic [15:0] da,
                             logic [31:0] dd, bit eig, bit edg, bit ew, logic [15:0] ea,
                             bit eirv, bit edrv, logic [31:0] erd);
    vec_t t;
    t.rst = rst; t.ir = ir; t.ia = ia; t.dr = dr; t.dw = dw; t.da = da; t.dd = dd;
    t.eig = eig; t.edg = edg; t.ew = ew; t.ea = ea; t.eirv = eirv; t.edrv = edrv; t.erd = erd;
    return t;
  endfunction

  vec_t tbl[$];

  initial begin
    bit pi, pd, pw, last_d, rst;
    logic [15:0] pa, pda;
    logic [31:0] pdd, rdat;
    int resp, win;
    for (int a = 0; a < 65536; a++) ram[a] = init_val(a);
    tbl.push_back(v(0, 1, 16'h4, 1, 0, 16'h10, 0, 0, 0, 0, 16'h4, 0, 0, 0));
    tbl.push_back(v(0, 0, 16'h4, 0, 0, 16'h10, 0, 0, 0, 0, 16'h4, 0, 0, 0));
    tbl.push_back(v(1, 0, 16'h4, 1, 1, 16'h10, W, 0, 1, 1, 16'h10, 0, 0, 0));
    tbl.push_back(v(1, 0, 16'h4, 1, 0, 16'h10, 0, 0, 1, 0, 16'h10, 0, 0, 0));
    tbl.push_back(v(1, 0, 16'h4, 0, 0, 16'h10, 0, 0, 0, 0, 16'h4, 0, 1, W));
    tbl.push_back(v(1, 0, 16'h4, 0, 0, 16'h10, 0, 0, 0, 0, 16'h4, 0, 0, 0));
    tbl.push_back(v(1, 0, 16'h4, 0, 0, 16'h10, 0, 0, 0, 0, 16'h4, 0, 0, 0));
    tbl.push_back(v(0, 0, 16'h4, 0, 0, 16'h10, 0, 0, 0, 0, 16'h4, 0, 0, 0));
    for (int k = 0; k < 4; k++) begin
      bit ig = RR && k[0];
      tbl.push_back(v(1, 1, 16'h4, 1, 0, 16'h10, 0, ig, !ig, 0, ig ? 16'h4 : 16'h10,
                      RR && k > 0 && !k[0], k > 0 && !(RR && !k[0]), (RR && !k[0]) ? C : W));
    end
    tbl.push_back(v(1, 0, 16'h4, 0, 0, 16'h10, 0, 0, 0, 0, 16'h4, RR, !RR, RR ? C : W));
    tbl.push_back(v(1, 1, 16'h4, 0, 0, 16'h10, 0, 1, 0, 0, 16'h4, 0, 0, 0));
    tbl.push_back(v(0, 1, 16'h4, 0, 0, 16'h10, 0, 0, 0, 0, 16'h4, 0, 0, 0));
    tbl.push_back(v(1, 0, 16'h4, 0, 0, 16'h10, 0, 0, 0, 0, 16'h4, 0, 0, 0));
    foreach (tbl[n]) begin
      rst_n = tbl[n].rst; i_req = tbl[n].ir; i_addr = tbl[n].ia;
      d_req = tbl[n].dr; d_we = tbl[n].dw; d_addr = tbl[n].da; d_wdata = tbl[n].dd;
      @(negedge clk);
      chk($sformatf("row%0d i_gnt", n), 32'(i_gnt), 32'(tbl[n].eig));
      chk($sformatf("row%0d d_gnt", n), 32'(d_gnt), 32'(tbl[n].edg));
      chk($sformatf("row%0d mem_W", n), 32'(mem_W), 32'(tbl[n].ew));
      chk($sformatf("row%0d mem_A", n), 32'(mem_A), 32'(tbl[n].ea));
      if (tbl[n].ew) chk($sformatf("row%0d mem_D", n), mem_D, tbl[n].dd);
      chk($sformatf("row%0d i_rvalid", n), 32'(i_rvalid), 32'(tbl[n].eirv));
      chk($sformatf("row%0d d_rvalid", n), 32'(d_rvalid), 32'(tbl[n].edrv));
      if (tbl[n].eirv) chk($sformatf("row%0d i_rdata", n), i_rdata, tbl[n].erd);
      if (tbl[n].edrv) chk($sformatf("row%0d d_rdata", n), d_rdata, tbl[n].erd);
      @(posedge clk); #1;
    end
    // randomized traffic: each requester holds its request until granted
    pi = 0; pd = 0; pw = 0; pa = 0; pda = 0; pdd = 0; last_d = 0; resp = 0; rdat = 0;
    rst_n = 0; i_req = 0; d_req = 0;
    @(posedge clk); #1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (!pi && $urandom_range(2) == 0) begin pi = 1; pa = 16'($urandom_range(7)); end
      if (!pd && $urandom_range(2) == 0) begin
        pd = 1; pw = 1'($urandom_range(1)); pda = 16'($urandom_range(7)); pdd = $urandom;
      end
      rst = ($urandom_range(24) != 0);
      rst_n = rst; i_req = pi; i_addr = pi ? pa : 16'($urandom_range(7));
      d_req = pd; d_we = pw; d_addr = pda; d_wdata = pdd;
      if (!rst) win = 0;
      else if (pi && pd) win = (RR && last_d) ? 1 : 2;
      else win = pi ? 1 : pd ? 2 : 0;
      @(negedge clk);
      chk($sformatf("rnd%0d i_gnt", cyc), 32'(i_gnt), 32'(win == 1));
      chk($sformatf("rnd%0d d_gnt", cyc), 32'(d_gnt), 32'(win == 2));
      chk($sformatf("rnd%0d mem_W", cyc), 32'(mem_W), 32'(win == 2 && pw));
      chk($sformatf("rnd%0d mem_A", cyc), 32'(mem_A), 32'(win == 2 ? pda : i_addr));
      if (win == 2 && pw) chk($sformatf("rnd%0d mem_D", cyc), mem_D, pdd);
      chk($sformatf("rnd%0d i_rvalid", cyc), 32'(i_rvalid), 32'(rst && resp == 1));
      chk($sformatf("rnd%0d d_rvalid", cyc), 32'(d_rvalid), 32'(rst && resp == 2));
      if (rst && resp == 1) chk($sformatf("rnd%0d i_rdata", cyc), i_rdata, rdat);
      if (rst && resp == 2) chk($sformatf("rnd%0d d_rdata", cyc), d_rdata, rdat);
      resp = 0;
      if (!rst) last_d = 0;
      if (win == 1) begin
        resp = 1; rdat = mem_get(int'(pa)); pi = 0; last_d = 0;
      end else if (win == 2) begin
        if (pw) mm[int'(pda)] = pdd;
        else begin resp = 2; rdat = mem_get(int'(pda)); end
        pd = 0; last_d = 1;
      end
      @(posedge clk); #1;
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WORD, default 32: data word width in bits.
REQ-002 Parameter ADDR, default 16: word address width in bits.
REQ-003 Port clk  input  1: the single clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1: reset, synchronous and active-low.
REQ-005 Port i_req  input  1: instruction-port read request.
REQ-006 Port i_addr  input  ADDR: instruction-port word address.
REQ-007 Port i_gnt  output  1: instruction request accepted this cycle.
REQ-008 Port i_rvalid  output  1: i_rdata valid this cycle.
REQ-009 Port i_rdata  output  WORD: instruction read data.
REQ-010 Port d_req  input  1: data-port request.
REQ-011 Port d_we  input  1: data-port write (1) or read (0).
REQ-012 Port d_addr  input  ADDR: data-port word address.
REQ-013 Port d_wdata  input  WORD: data-port write data.
REQ-014 Port d_gnt  output  1: data request accepted this cycle.
REQ-015 Port d_rvalid  output  1: d_rdata valid this cycle.
REQ-016 Port d_rdata  output  WORD: data read data.
REQ-017 Ports mem_A (output, ADDR), mem_W (output, 1), mem_D (output, WORD), mem_Q (input, WORD) SHALL connect to the single-port memory: write when W=1, otherwise registered read with Q valid one cycle after the address edge.

Function
REQ-018 Grant SHALL be combinational in the request cycle; a request is consumed at the rising edge where its gnt=1, and requesters SHALL hold req/addr/we/wdata stable until granted.
REQ-019 At most one of i_gnt, d_gnt SHALL be 1 in any cycle; with exactly one request present, that request SHALL be granted.
REQ-020 mem_A/mem_W/mem_D SHALL be driven combinationally from the granted port; d grant: mem_A=d_addr, mem_W=d_we, mem_D=d_wdata; i grant: mem_A=i_addr, mem_W=0.
REQ-021 With no grant, mem_W SHALL be 0 and mem_A SHALL be i_addr (harmless read, no response).
REQ-022 A read granted in cycle t SHALL give rvalid=1 on the owning port in cycle t+1 only, with rdata=mem_Q; latency is exactly 1 cycle.
REQ-023 Granted writes SHALL produce no rvalid on either port.
REQ-024 A registered response-owner state (NONE, RESP_I, RESP_D) SHALL be loaded every edge from the current grant (read->RESP_I/RESP_D, write or none->NONE).
REQ-025 i_rdata and d_rdata SHALL both present mem_Q; only rvalid distinguishes the owner.
REQ-026 Back-to-back grants SHALL be allowed every cycle; sustained throughput is one access per cycle.
REQ-027 Read-after-write to the same address in consecutive cycles SHALL return the newly written data.

Reset
REQ-028 While rst_n=0 at an edge: owner state SHALL become NONE and the round-robin pointer (if compiled) SHALL become "last=I".
REQ-029 While rst_n=0: i_gnt=0, d_gnt=0, mem_W=0 combinationally; i_rvalid=0, d_rvalid=0 in the cycle after the reset edge.
REQ-030 A read granted in the cycle before reset asserts SHALL produce no rvalid.

Configuration
REQ-031 Macro ARB_RR_EN defined: round-robin; on simultaneous requests, grant the port not granted most recently; a 1-bit last-grant register updates only on a grant.
REQ-032 Macro ARB_RR_EN undefined: fixed priority, d over i on simultaneous requests; no pointer register.

Verification
REQ-033 Reset release, d_req=1, d_we=1, d_addr=0x0010, d_wdata=0xDEADBEEF -> d_gnt=1 same cycle, mem_W=1, no rvalid next cycle.
REQ-034 Next cycle d_req=1, d_we=0, d_addr=0x0010 -> d_gnt=1; following cycle d_rvalid=1, d_rdata=0xDEADBEEF, i_rvalid=0.
REQ-035 i_req=1 and d_req=1 (read) held 4 cycles, ARB_RR_EN undefined -> d_gnt=1 every cycle, i_gnt=0 throughout.
REQ-036 Same stimulus, ARB_RR_EN defined, after reset -> grants alternate d,i,d,i; rvalid alternates one cycle later on the matching port.
REQ-037 i_req=1, i_addr=0x0004 granted in cycle t, rst_n=0 in cycle t+1 -> i_rvalid=0 in t+1 and t+2; i_gnt=0 while rst_n=0.
REQ-038 No requests for 3 cycles -> i_gnt=d_gnt=0, mem_W=0, i_rvalid=d_rvalid=0.
